fsm_stream_arbiter: RTL

FSM_STREAM_ARBITER -- requirements
Module: fsm_stream_arbiter

---
 rtl/fsm_stream_arbiter_if.sv | 27 ++
 rtl/fsm_stream_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fsm_stream_arbiter_if.sv
// Request/payload and serial-stream bundle between two requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface fsm_stream_arbiter_if #(
    parameter int unsigned FRAME_W = 8
);
    logic               req0;
    logic               req1;
    logic [FRAME_W-1:0] data0;
    logic [FRAME_W-1:0] data1;
    logic               gnt0;
    logic               gnt1;
    logic               ser_en;
    logic               ser_bit;
    logic               owner;
    logic               busy;
    logic               done;

    modport master (
        output req0, req1, data0, data1,
        input  gnt0, gnt1, ser_en, ser_bit, owner, busy, done
    );

    modport slave (
        input  req0, req1, data0, data1,
        output gnt0, gnt1, ser_en, ser_bit, owner, busy, done
    );
endinterface

// File: rtl/fsm_stream_arbiter.sv
// Two-requester round-robin arbiter that serializes the winning payload MSB first,
// followed by a fixed idle gap. All outputs are registered.
module fsm_stream_arbiter #(
    parameter int unsigned FRAME_W = 8,
    parameter int unsigned GAP     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fsm_stream_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(FRAME_W);
    localparam int unsigned GAP_W = 4;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               owner_q, owner_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               ser_en_q, ser_en_d;
    logic               ser_bit_q, ser_bit_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               win_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        owner_d   = owner_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        win_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Under contention the previous owner yields.
                    win_c     = (bus.req0 && bus.req1) ? ~owner_q : bus.req1;
                    shift_d   = win_c ? bus.data1 : bus.data0;
                    owner_d   = win_c;
                    bit_cnt_d = '0;
                    gnt0_d    = ~win_c;
                    gnt1_d    = win_c;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_LAST) begin
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stream outputs follow the state being entered so they register in step with it.
        ser_en_d  = (state_d == ST_SHIFT);
        busy_d    = (state_d != ST_IDLE);
        ser_bit_d = ser_en_d & shift_d[FRAME_W-1];
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            owner_q   <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            ser_en_q  <= 1'b0;
            ser_bit_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            owner_q   <= owner_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            ser_en_q  <= ser_en_d;
            ser_bit_q <= ser_bit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.ser_en  = ser_en_q;
    assign bus.ser_bit = ser_bit_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
